prbs7_xnor_checker: RTL and testbench

- Serial PRBS-7 checker: the receiving end of an XNOR-feedback PRBS-7 generator (polynomial x^7 + x^6 + 1).
- Self-synchronises its 7-bit reference register to the incoming stream, declares lock, then compares every valid bit against its own prediction.
- Counts bit errors and drops lock when errors get too dense.
- Sits on the RX side of serial link and self-test paths.

---
 rtl/prbs7_xnor_checker_if.sv | 23 ++
 rtl/prbs7_xnor_checker.sv | 121 ++++++++++++
 tb/tb_prbs7_xnor_checker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs7_xnor_checker_if.sv
// Receive-side bundle for the PRBS-7 checker.
// The stream source uses master; the checker uses slave.
interface prbs7_xnor_checker_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_bit;
    logic                 clear_cnt;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 lock_lost;

    modport master (
        output in_valid, in_bit, clear_cnt,
        input  locked, err_pulse, err_count, lock_lost
    );

    modport slave (
        input  in_valid, in_bit, clear_cnt,
        output locked, err_pulse, err_count, lock_lost
    );
endinterface

// File: rtl/prbs7_xnor_checker.sv
// Serial PRBS-7 checker for an XNOR generator (x^7 + x^6 + 1).
// It self-synchronises, locks, then counts errors against a free-running reference.
module prbs7_xnor_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW_LEN  = 64,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    prbs7_xnor_checker_if.slave bus
);
    localparam int              WIN_W   = $clog2(WINDOW_LEN + 1);
    localparam logic [7:0]      LOCK_V  = 8'(LOCK_COUNT);
    localparam logic [WIN_W-1:0] WIN_V  = WIN_W'(WINDOW_LEN);
    localparam logic [WIN_W-1:0] UNL_V  = WIN_W'(UNLOCK_ERRS);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t               state, state_n;
    logic [6:0]           sr, sr_n;
    logic [2:0]           fill_cnt, fill_cnt_n;
    logic [7:0]           match_cnt, match_cnt_n;
    logic [WIN_W-1:0]     win_cnt, win_cnt_n;
    logic [WIN_W-1:0]     win_err, win_err_n;
    logic [ERR_CNT_W-1:0] err_count, err_count_n;
    logic                 locked, locked_n;
    logic                 err_pulse, err_pulse_n;
    logic                 lock_lost, lock_lost_n;
    logic                 pred;

    assign pred = ~(sr[6] ^ sr[5]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            sr        <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_count <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            fill_cnt  <= fill_cnt_n;
            match_cnt <= match_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            err_count <= err_count_n;
            locked    <= locked_n;
            err_pulse <= err_pulse_n;
            lock_lost <= lock_lost_n;
        end
    end

    always_comb begin
        state_n     = state;
        sr_n        = sr;
        fill_cnt_n  = fill_cnt;
        match_cnt_n = match_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        err_count_n = err_count;
        err_pulse_n = 1'b0;
        lock_lost_n = 1'b0;

        // Clear first so a same-cycle mismatch still lands as a count of one.
        if (bus.clear_cnt) err_count_n = '0;

        if (bus.in_valid) begin
            case (state)
                SEARCH: begin
                    sr_n = {sr[5:0], bus.in_bit};
                    if (fill_cnt != 3'd7) begin
                        fill_cnt_n = fill_cnt + 3'd1;
                    end else if ((bus.in_bit == pred) && (sr != 7'h7f)) begin
                        match_cnt_n = match_cnt + 8'd1;
                        if (match_cnt_n == LOCK_V) begin
                            state_n   = LOCKED;
                            win_cnt_n = '0;
                            win_err_n = '0;
                        end
                    end else begin
                        match_cnt_n = '0;
                    end
                end
                LOCKED: begin
                    sr_n      = {sr[5:0], pred};
                    win_cnt_n = win_cnt + 1'b1;
                    if (bus.in_bit != pred) begin
                        err_pulse_n = 1'b1;
                        win_err_n   = win_err + 1'b1;
                        if (err_count_n != '1) err_count_n = err_count_n + 1'b1;
                    end
                    // Unlock takes priority over the window closing on the same bit.
                    if ((bus.in_bit != pred) && (win_err_n == UNL_V)) begin
                        state_n     = SEARCH;
                        lock_lost_n = 1'b1;
                        fill_cnt_n  = '0;
                        match_cnt_n = '0;
                    end else if (win_cnt_n == WIN_V) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        locked_n = (state_n == LOCKED);
    end

    assign bus.locked    = locked;
    assign bus.err_pulse = err_pulse;
    assign bus.err_count = err_count;
    assign bus.lock_lost = lock_lost;
endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Scoreboard bench for prbs7_xnor_checker: a behavioural model queues expected
// outputs per driven cycle; a second instance with a 4-bit counter checks saturation.
module tb_prbs7_xnor_checker;
    localparam int LOCK  = 16;
    localparam int WIN   = 64;
    localparam int UNLK  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs7_xnor_checker_if #(.ERR_CNT_W(16)) bus  ();
    prbs7_xnor_checker_if #(.ERR_CNT_W(4))  bus4 ();

    prbs7_xnor_checker #(.LOCK_COUNT(LOCK), .WINDOW_LEN(WIN), .UNLOCK_ERRS(UNLK), .ERR_CNT_W(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    prbs7_xnor_checker #(.LOCK_COUNT(LOCK), .WINDOW_LEN(WIN), .UNLOCK_ERRS(UNLK), .ERR_CNT_W(4))
        dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic        ll;
        logic [15:0] ec;
        logic [3:0]  ec4;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;
    int   losts  = 0;
    int   lock_hi = 0;
    logic raw_mode = 1'b0;

    // generator and model state
    logic [6:0]  g;
    logic [6:0]  m_sr;
    logic        m_locked;
    int          m_fill, m_match, m_wc, m_we;
    logic [15:0] m_ec;
    logic [3:0]  m_ec4;

    task automatic model_reset();
        g = '0; m_sr = '0; m_locked = 1'b0;
        m_fill = 0; m_match = 0; m_wc = 0; m_we = 0;
        m_ec = '0; m_ec4 = '0;
    endtask

    task automatic drive(input logic v, input logic b, input logic clr);
        bus.in_valid = v;  bus.in_bit = b;  bus.clear_cnt = clr;
        bus4.in_valid = v; bus4.in_bit = b; bus4.clear_cnt = clr;
    endtask

    task automatic send(input logic v, input logic inv, input logic clr);
        logic b, p, ep, ll;
        exp_t e, got;
        @(negedge clk);
        b = 1'b0;
        if (v) begin
            if (raw_mode) b = 1'b1;
            else begin
                b = ~(g[6] ^ g[5]);
                g = {g[5:0], b};
            end
            b = b ^ inv;
        end
        drive(v, b, clr);
        ep = 1'b0; ll = 1'b0;
        if (clr) begin m_ec = '0; m_ec4 = '0; end
        if (v) begin
            p = ~(m_sr[6] ^ m_sr[5]);
            if (!m_locked) begin
                if (m_fill < 7) m_fill++;
                else if (b == p && m_sr != 7'h7f) begin
                    m_match++;
                    if (m_match == LOCK) begin m_locked = 1'b1; m_wc = 0; m_we = 0; end
                end else m_match = 0;
                m_sr = {m_sr[5:0], b};
            end else begin
                m_sr = {m_sr[5:0], p};
                m_wc++;
                if (b != p) begin
                    ep = 1'b1; m_we++;
                    if (m_ec != 16'hffff) m_ec++;
                    if (m_ec4 != 4'hf) m_ec4++;
                end
                if (b != p && m_we == UNLK) begin
                    m_locked = 1'b0; ll = 1'b1; m_fill = 0; m_match = 0;
                end else if (m_wc == WIN) begin
                    m_wc = 0; m_we = 0;
                end
            end
        end
        e = '{lk: m_locked, ep: ep, ll: ll, ec: m_ec, ec4: m_ec4};
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        total++;
        if (bus.locked !== got.lk) begin bad++; $display("FAIL sb_locked got=%b exp=%b t=%0t", bus.locked, got.lk, $time); end
        total++;
        if (bus.err_pulse !== got.ep) begin bad++; $display("FAIL sb_err_pulse got=%b exp=%b t=%0t", bus.err_pulse, got.ep, $time); end
        total++;
        if (bus.lock_lost !== got.ll) begin bad++; $display("FAIL sb_lock_lost got=%b exp=%b t=%0t", bus.lock_lost, got.ll, $time); end
        total++;
        if (bus.err_count !== got.ec) begin bad++; $display("FAIL sb_err_count got=%0d exp=%0d t=%0t", bus.err_count, got.ec, $time); end
        total++;
        if (bus4.err_count !== got.ec4) begin bad++; $display("FAIL sb_err_count4 got=%0d exp=%0d t=%0t", bus4.err_count, got.ec4, $time); end
        if (bus.err_pulse === 1'b1) pulses++;
        if (bus.lock_lost === 1'b1) losts++;
        if (bus.locked === 1'b1) lock_hi++;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.locked, bus.err_pulse, bus.lock_lost} !== 3'b000 || bus.err_count !== 16'd0) begin
            bad++;
            $display("FAIL %s flags=%b%b%b count=%0d exp flags=000 count=0", tag,
                     bus.locked, bus.err_pulse, bus.lock_lost, bus.err_count);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic lock_from_zero(input string tag);
        for (int i = 1; i <= 23; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (i == 22) begin
                total++;
                if (bus.locked !== 1'b0) begin bad++; $display("FAIL %s_early got=%b exp=0", tag, bus.locked); end
            end
        end
        total++;
        if (bus.locked !== 1'b1) begin bad++; $display("FAIL %s_at23 got=%b exp=1", tag, bus.locked); end
    endtask

    task automatic test_reset();
        apply_reset("reset_init");
    endtask

    task automatic test_clean_lock();
        lock_from_zero("clean_lock");
        repeat (200) send(1'b1, 1'b0, 1'b0);
        total++;
        if (bus.err_count !== 16'd0 || bus.locked !== 1'b1) begin
            bad++; $display("FAIL clean_run count=%0d locked=%b exp count=0 locked=1", bus.err_count, bus.locked);
        end
    endtask

    task automatic test_single_error();
        int p0, h0;
        p0 = pulses; h0 = lock_hi;
        send(1'b1, 1'b1, 1'b0);
        repeat (100) send(1'b1, 1'b0, 1'b0);
        total++;
        if (pulses - p0 != 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", pulses - p0); end
        total++;
        if (bus.err_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.err_count); end
        total++;
        if (lock_hi - h0 != 101) begin bad++; $display("FAIL single_locked cycles=%0d exp=101", lock_hi - h0); end
    endtask

    task automatic test_unlock();
        int p0, l0;
        apply_reset("reset_pre_unlock");
        lock_from_zero("unlock_lock");
        p0 = pulses; l0 = losts;
        for (int i = 0; i < 7; i++) send(1'b1, (i % 2) == 0, 1'b0);
        total++;
        if (pulses - p0 != 4 || bus.err_count !== 16'd4) begin
            bad++; $display("FAIL unlock_errs pulses=%0d count=%0d exp 4/4", pulses - p0, bus.err_count);
        end
        total++;
        if (losts - l0 != 1 || bus.locked !== 1'b0) begin
            bad++; $display("FAIL unlock_lost lost=%0d locked=%b exp 1/0", losts - l0, bus.locked);
        end
        lock_from_zero("relock");
    endtask

    task automatic test_sparse();
        int l0;
        l0 = losts;
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < 64; i++)
                send(1'b1, (i == 10 || i == 20 || i == 30), (w == 0 && i == 0));
        total++;
        if (bus.err_count !== 16'd15) begin bad++; $display("FAIL sparse_count got=%0d exp=15", bus.err_count); end
        total++;
        if (losts != l0 || bus.locked !== 1'b1) begin
            bad++; $display("FAIL sparse_lock lost=%0d locked=%b exp 0/1", losts - l0, bus.locked);
        end
    endtask

    task automatic test_saturate();
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 64; i++)
                send(1'b1, (i == 10 || i == 20), 1'b0);
        total++;
        if (bus4.err_count !== 4'd15) begin bad++; $display("FAIL sat4_count got=%0d exp=15", bus4.err_count); end
        total++;
        if (bus.err_count !== 16'd21) begin bad++; $display("FAIL sat16_count got=%0d exp=21", bus.err_count); end
    endtask

    task automatic test_clear_collide();
        send(1'b1, 1'b1, 1'b1);
        total++;
        if (bus.err_count !== 16'd1 || bus4.err_count !== 4'd1) begin
            bad++; $display("FAIL clear_collide got=%0d/%0d exp=1/1", bus.err_count, bus4.err_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset("reset_mid");
    endtask

    task automatic test_all_ones();
        int h0;
        h0 = lock_hi;
        raw_mode = 1'b1;
        repeat (500) send(1'b1, 1'b0, 1'b0);
        raw_mode = 1'b0;
        total++;
        if (lock_hi != h0) begin bad++; $display("FAIL all_ones locked_cycles=%0d exp=0", lock_hi - h0); end
    endtask

    task automatic test_gaps();
        int p0;
        apply_reset("reset_pre_gaps");
        p0 = pulses;
        for (int vc = 1; vc <= 150; vc++) begin
            repeat ($urandom_range(0, 3)) send(1'b0, 1'b0, 1'b0);
            send(1'b1, vc == 60, 1'b0);
            if (vc == 22) begin
                total++;
                if (bus.locked !== 1'b0) begin bad++; $display("FAIL gaps_early got=%b exp=0", bus.locked); end
            end
            if (vc == 23) begin
                total++;
                if (bus.locked !== 1'b1) begin bad++; $display("FAIL gaps_lock got=%b exp=1", bus.locked); end
            end
        end
        total++;
        if (bus.err_count !== 16'd1 || pulses - p0 != 1) begin
            bad++; $display("FAIL gaps_errs count=%0d pulses=%0d exp 1/1", bus.err_count, pulses - p0);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_unlock();
        test_sparse();
        test_saturate();
        test_clear_collide();
        test_reset_mid();
        test_all_ones();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
